mdio_master: RTL and testbench

IEEE 802.3 Clause 22 MDIO management master for the Ethernet PHY. It serialises one read or write frame per request on phymdc/MDIO and deserialises read data. It sits under the Ethernet slow-control register block, which issues requests and reads results. It replaces the static stub that currently parks phymdc low and MDIO tri-stated. The top level builds the phymdio inout from mdio_o/mdio_oe/mdio_i.

---
 rtl/mdio_master.sv | 177 +++++++++++++++++
 tb/tb_mdio_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO management master: serialises one read or write frame per start.
// Optional build macro MDIO_PRESUP_EN enables preamble suppression through the no_pre input.
module mdio_master #(
   parameter int CLKDIV   = 25,
   parameter int PREAMBLE = 32
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        start,
   input  logic        op_read,
   input  logic [4:0]  phy_addr,
   input  logic [4:0]  reg_addr,
   input  logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        rd_err,
   output logic        phymdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i,
   input  logic        no_pre
);

   localparam int               BIT_CLKS = 2 * CLKDIV;
   localparam int               DIV_W    = $clog2(BIT_CLKS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CLKS - 1);
   localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLKDIV);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [5:0]       PRE_LAST = 6'(PREAMBLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA
   } state_t;

   state_t            state_q, state_d, first_state;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [5:0]        bit_q, bit_d;
   logic [31:0]       tx_q, tx_d;
   logic [14:0]       rx_q, rx_d;
   logic              is_read_q, is_read_d;
   logic              ta_err_q, ta_err_d;
   logic              done_d;
   logic [15:0]       rd_data_d;
   logic              rd_err_d;
   logic              mdc_d, mdio_o_d, mdio_oe_d;
   logic              bit_end;

`ifdef MDIO_PRESUP_EN
   assign first_state = no_pre ? S_HDR : S_PRE;
`else
   logic unused_no_pre;
   assign unused_no_pre = no_pre;
   assign first_state   = S_PRE;
`endif

   assign busy = (state_q != S_IDLE);

   always_comb begin
      // NOTE: every signal gets a default first so no path can hold a value, which would infer a latch.
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      is_read_d = is_read_q;
      ta_err_d  = ta_err_q;
      done_d    = 1'b0;
      rd_data_d = rd_data;
      rd_err_d  = rd_err;
      bit_end   = (div_q == DIV_LAST);

      if (state_q == S_IDLE) begin
         // A start landing in the done cycle is dropped, not queued.
         if (start && !done) begin
            state_d   = first_state;
            div_d     = '0;
            bit_d     = '0;
            tx_d      = {2'b01, (op_read ? 2'b10 : 2'b01), phy_addr, reg_addr, 2'b10, wr_data};
            is_read_d = op_read;
         end
      end else begin
         div_d = bit_end ? '0 : div_q + DIV_ONE;
         if (bit_end) begin
            bit_d = bit_q + 6'd1;
            // The preamble is not part of the shift register, so it must not consume ST bits.
            if (state_q != S_PRE) tx_d = {tx_q[30:0], 1'b1};
            case (state_q)
               S_PRE: begin
                  if (bit_q == PRE_LAST) begin
                     state_d = S_HDR;
                     bit_d   = '0;
                  end
               end
               S_HDR: begin
                  if (bit_q == 6'd13) begin
                     state_d = S_TA;
                     bit_d   = '0;
                  end
               end
               S_TA: begin
                  if (bit_q == 6'd1) begin
                     state_d  = S_DATA;
                     bit_d    = '0;
                     ta_err_d = mdio_i;
                  end
               end
               S_DATA: begin
                  rx_d = {rx_q[13:0], mdio_i};
                  if (bit_q == 6'd15) begin
                     state_d = S_IDLE;
                     bit_d   = '0;
                     done_d  = 1'b1;
                     if (is_read_q) begin
                        rd_data_d = {rx_q, mdio_i};
                        rd_err_d  = ta_err_q;
                     end else begin
                        rd_err_d  = 1'b0;
                     end
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  bit_d   = '0;
               end
            endcase
         end
      end

      // Pin values are computed for the next bit position and registered, so the pins never glitch.
      mdc_d     = (state_d != S_IDLE) && (div_d >= DIV_HIGH);
      mdio_oe_d = (state_d == S_PRE) || (state_d == S_HDR) ||
                  (!is_read_d && ((state_d == S_TA) || (state_d == S_DATA)));
      if (state_d == S_PRE)
         mdio_o_d = 1'b1;
      else
         mdio_o_d = mdio_oe_d ? tx_d[31] : 1'b1;
   end

   always_ff @(posedge wb_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      if (wb_rst) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         is_read_q <= 1'b0;
         ta_err_q  <= 1'b0;
         done      <= 1'b0;
         rd_data   <= '0;
         rd_err    <= 1'b0;
         phymdc    <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         is_read_q <= is_read_d;
         ta_err_q  <= ta_err_d;
         done      <= done_d;
         rd_data   <= rd_data_d;
         rd_err    <= rd_err_d;
         phymdc    <= mdc_d;
         mdio_o    <= mdio_o_d;
         mdio_oe   <= mdio_oe_d;
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: frame-level reference model, PHY responder, directed tests.
// Build with MDIO_PRESUP_EN defined to exercise preamble suppression.
module tb_mdio_master;

   localparam int CLKDIV   = 2;
   localparam int PREAMBLE = 32;
   localparam int BITCLK   = 2 * CLKDIV;

`ifdef MDIO_PRESUP_EN
   localparam bit PRESUP = 1'b1;
`else
   localparam bit PRESUP = 1'b0;
`endif
   localparam int          LAT_NP  = PRESUP ? 129 : 257;
   localparam logic [63:0] BITS_NP = PRESUP ? 64'h0000_0000_5082_1140 : 64'hFFFF_FFFF_5082_1140;

   logic        wb_clk, wb_rst, start, op_read, no_pre, mdio_i;
   logic [4:0]  phy_addr, reg_addr;
   logic [15:0] wr_data;
   logic        busy, done, rd_err, phymdc, mdio_o, mdio_oe;
   logic [15:0] rd_data;

   mdio_master #(.CLKDIV(CLKDIV), .PREAMBLE(PREAMBLE)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .op_read(op_read),
      .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_err(rd_err),
      .phymdc(phymdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i), .no_pre(no_pre)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      wb_clk = 1'b0;
      forever #5 wb_clk = ~wb_clk;
   end

   initial forever begin
      @(posedge wb_clk);
      cyc++;
   end

   // Frame as it must appear on the wire: bit n (wire order) value and whether the master drives it.
   typedef struct {
      logic [63:0] val;
      logic [63:0] drv;
      int          len;
      logic        rd;
   } frame_t;

   function automatic frame_t build_frame(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                                          input logic [15:0] wd, input logic np);
      frame_t      f;
      int          n;
      logic [31:0] body;
      f.val = '0;
      f.drv = '0;
      f.rd  = rd;
      n     = 0;
      if (!(np && PRESUP)) begin
         for (int i = 0; i < PREAMBLE; i++) begin
            f.val[n] = 1'b1;
            f.drv[n] = 1'b1;
            n++;
         end
      end
      body = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra, 2'b10, wd};
      for (int i = 31; i >= 0; i--) begin
         f.val[n] = body[i];
         f.drv[n] = !rd || (i >= 18);
         n++;
      end
      f.len = n;
      return f;
   endfunction

   // PHY behaviour chosen by the tests.
   bit          phy_present = 1'b1;
   logic [15:0] phy_data    = 16'h0000;

   // Reference model: frame position counted in clocks since acceptance.
   frame_t      m_f;
   bit          m_active  = 1'b0;
   bit          m_done    = 1'b0;
   int          m_k       = 0;
   logic [15:0] m_rd_data = 16'h0000;
   logic        m_rd_err  = 1'b0;

   initial forever begin
      @(posedge wb_clk);
      if (wb_rst) begin
         m_active  = 1'b0;
         m_done    = 1'b0;
         m_rd_data = 16'h0000;
         m_rd_err  = 1'b0;
      end else if (m_active) begin
         if (m_k == m_f.len * BITCLK - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            if (m_f.rd) begin
               m_rd_data = phy_present ? phy_data : 16'hFFFF;
               m_rd_err  = !phy_present;
            end else begin
               m_rd_err  = 1'b0;
            end
         end else begin
            m_k++;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (start) begin
         m_f      = build_frame(op_read, phy_addr, reg_addr, wr_data, no_pre);
         m_active = 1'b1;
         m_k      = 0;
      end
   end

   // PHY responder: presents each read-phase bit just after the MDC rising edge of that bit.
   initial begin
      mdio_i = 1'b1;
      forever begin
         @(negedge wb_clk);
         if (m_active && m_f.rd && phy_present) begin
            int b, t;
            b = m_k / BITCLK;
            t = b - (m_f.len - 18);
            if ((m_k % BITCLK) == CLKDIV) begin
               if (t < 1)       mdio_i = 1'b1;
               else if (t == 1) mdio_i = 1'b0;
               else             mdio_i = phy_data[17 - t];
            end
         end else begin
            mdio_i = 1'b1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial forever begin
      @(negedge wb_clk);
      if (cmp_en) begin
         if (m_active) begin
            int b, p;
            b = m_k / BITCLK;
            p = m_k % BITCLK;
            check("busy", busy, 1'b1);
            check("done", done, 1'b0);
            check("mdc", phymdc, (p >= CLKDIV));
            check("oe", mdio_oe, m_f.drv[b]);
            if (m_f.drv[b]) check("mdio_o", mdio_o, m_f.val[b]);
         end else begin
            check("busy_idle", busy, 1'b0);
            check("done_idle", done, m_done);
            check("mdc_idle", phymdc, 1'b0);
            check("oe_idle", mdio_oe, 1'b0);
            check("mdio_o_idle", mdio_o, 1'b1);
         end
         check("rd_data", rd_data, m_rd_data);
         check("rd_err", rd_err, m_rd_err);
      end
   end

   task automatic run_frame(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                            input logic [15:0] wd, input logic np, input bit stray,
                            output int lat, output logic [63:0] mbits, output logic [63:0] obits);
      int   c0;
      logic prev;
      bit   seen;
      mbits = '0;
      obits = '0;
      prev  = 1'b0;
      seen  = 1'b0;
      lat   = -1;
      @(negedge wb_clk);
      op_read = rd; phy_addr = pa; reg_addr = ra; wr_data = wd; no_pre = np; start = 1'b1;
      c0 = cyc;
      for (int rel = 1; rel <= 5000 && !seen; rel++) begin
         @(negedge wb_clk);
         start = 1'b0;
         if (stray && (rel == 10 || rel == 100)) begin
            op_read = 1'b1; phy_addr = 5'h1f; reg_addr = 5'h1f; wr_data = 16'h0000; start = 1'b1;
         end
         if (phymdc && !prev) begin
            mbits = {mbits[62:0], mdio_o};
            obits = {obits[62:0], mdio_oe};
         end
         prev = phymdc;
         if (done) begin
            lat  = cyc - c0;
            seen = 1'b1;
            if (stray) begin
               op_read = 1'b1; phy_addr = 5'h1e; reg_addr = 5'h1d; start = 1'b1;
            end
         end
      end
      check("frame_completed", seen, 1'b1);
      @(negedge wb_clk);
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int          lat, dcount, bcount;
      logic [63:0] mb, ob;
      wb_rst = 1'b1; start = 1'b0; op_read = 1'b0; no_pre = 1'b0;
      phy_addr = '0; reg_addr = '0; wr_data = '0;
      repeat (3) @(negedge wb_clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rd_data", rd_data, 16'h0000);
      check("rst_rd_err", rd_err, 1'b0);
      check("rst_mdc", phymdc, 1'b0);
      check("rst_mdio_o", mdio_o, 1'b1);
      check("rst_oe", mdio_oe, 1'b0);
      cmp_en = 1'b1;
      wb_rst = 1'b0;
      repeat (2) @(negedge wb_clk);

      // 1: write 0x1140 to PHY 1 register 0
      run_frame(1'b0, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b0, lat, mb, ob);
      check("t1_latency", lat, 257);
      check("t1_bits", mb, 64'hFFFF_FFFF_5082_1140);
      check("t1_oe", ob, 64'hFFFF_FFFF_FFFF_FFFF);

      // 2: read PHY 1 register 2 with a responding PHY
      phy_present = 1'b1; phy_data = 16'hABCD;
      run_frame(1'b1, 5'd1, 5'd2, 16'h0000, 1'b0, 1'b0, lat, mb, ob);
      check("t2_latency", lat, 257);
      check("t2_rd_data", rd_data, 16'hABCD);
      check("t2_rd_err", rd_err, 1'b0);
      check("t2_oe", ob, 64'hFFFF_FFFF_FFFC_0000);

      // 3: read with no PHY, then a write
      phy_present = 1'b0;
      run_frame(1'b1, 5'd7, 5'd3, 16'h0000, 1'b0, 1'b0, lat, mb, ob);
      check("t3_rd_data", rd_data, 16'hFFFF);
      check("t3_rd_err", rd_err, 1'b1);
      phy_present = 1'b1;
      run_frame(1'b0, 5'd3, 5'd4, 16'h0001, 1'b0, 1'b0, lat, mb, ob);
      check("t3_wr_rd_err", rd_err, 1'b0);
      check("t3_wr_rd_data", rd_data, 16'hFFFF);

      // 4: starts during a frame and in its done cycle are ignored
      run_frame(1'b0, 5'd5, 5'd6, 16'hA5C3, 1'b0, 1'b1, lat, mb, ob);
      check("t4_latency", lat, 257);
      check("t4_bits", mb, 64'hFFFF_FFFF_529A_A5C3);
      dcount = 0; bcount = 0;
      repeat (300) begin
         @(negedge wb_clk);
         if (done) dcount++;
         if (busy) bcount++;
      end
      check("t4_extra_done", dcount, 0);
      check("t4_extra_busy", bcount, 0);

      // 5: reset in the middle of the DATA phase of a write
      @(negedge wb_clk);
      op_read = 1'b0; phy_addr = 5'd2; reg_addr = 5'd9; wr_data = 16'h5A5A; start = 1'b1;
      @(negedge wb_clk);
      start = 1'b0;
      dcount = 0;
      repeat (218) begin
         @(negedge wb_clk);
         if (done) dcount++;
      end
      wb_rst = 1'b1;
      @(negedge wb_clk);
      wb_rst = 1'b0;
      check("t5_mdc", phymdc, 1'b0);
      check("t5_oe", mdio_oe, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      check("t5_rd_data", rd_data, 16'h0000);
      repeat (300) begin
         @(negedge wb_clk);
         if (done) dcount++;
      end
      check("t5_no_done", dcount, 0);
      phy_data = 16'h1234;
      run_frame(1'b1, 5'd4, 5'd1, 16'h0000, 1'b0, 1'b0, lat, mb, ob);
      check("t5_latency", lat, 257);
      check("t5_rd_data_after", rd_data, 16'h1234);
      check("t5_rd_err_after", rd_err, 1'b0);

      // 6: preamble suppression request, then the same write without it
      run_frame(1'b0, 5'd1, 5'd0, 16'h1140, 1'b1, 1'b0, lat, mb, ob);
      check("t6_np_latency", lat, LAT_NP);
      check("t6_np_bits", mb, BITS_NP);
      run_frame(1'b0, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b0, lat, mb, ob);
      check("t6_pre_latency", lat, 257);
      check("t6_pre_bits", mb, 64'hFFFF_FFFF_5082_1140);

      repeat (5) @(negedge wb_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
